id_operand_stage: RTL and testbench
===================================

Name: id_operand_stage

Overview:
- Decode/operand-fetch stage between the IF/ID register and the execute stage.
- Decodes the RV32I instruction word and drives the register file read addresses.
- Captures the returned operands, the generated immediate and control fields into an ID/EX pipeline register.
- Detects load-use hazards and writeback read-after-write hazards; inserts bubbles and back-pressures fetch.

Parameters:
XLEN, 32, datapath width; instruction word is always 32 bits.
AW, 5, register address width (32 architectural registers).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
id_valid  input  1  instruction on id_instr/id_pc is valid.
id_instr  input  32  instruction word.
id_pc  input  XLEN  PC of id_instr.
rs1  output  AW  register file read address 1 (id_instr[19:15]), combinational.
rs2  output  AW  register file read address 2 (id_instr[24:20]), combinational.
rd1  input  XLEN  register file read data 1.
rd2  input  XLEN  register file read data 2.
wb_we  input  1  writeback write enable (same signal that writes the register file).
wb_rd  input  AW  writeback destination.
wb_wd  input  XLEN  writeback data.
ex_hold  input  1  execute stage cannot accept; hold ID/EX contents.
flush  input  1  branch/jump redirect; kill the instruction in ID and ID/EX.
id_stall  output  1  fetch must hold IF/ID this cycle, combinational.
ex_valid  output  1  ID/EX holds a valid instruction.
ex_pc  output  XLEN  captured PC.
ex_opcode  output  7  id_instr[6:0].
ex_funct3  output  3  id_instr[14:12].
ex_funct7b5  output  1  id_instr[30].
ex_rd  output  AW  destination; 0 if the instruction writes no register.
ex_rs1_val  output  XLEN  operand 1.
ex_rs2_val  output  XLEN  operand 2.
ex_imm  output  XLEN  sign-extended immediate.
ex_is_load  output  1  opcode is LOAD (0000011).
ex_illegal  output  1  opcode not in the RV32I base set.

Behaviour:
- Reset: all ex_* outputs 0; id_stall 0 while rst is high.
- Latency: one cycle from ID capture to ex_* outputs.
- Operand uses by opcode:
  - rs1 used: all opcodes except LUI, AUIPC, JAL.
  - rs2 used: OP, STORE, BRANCH.
  - Unused operands: ex_rs*_val = 0.
- rd written: all opcodes except STORE and BRANCH; otherwise ex_rd = 0.
- x0 operands: when rs1 or rs2 = 0, the operand is 0 regardless of rd1/rd2 or bypass.
- Immediates: I, S, B, U and J formats sign-extended from bit 31 to XLEN. OP opcode gives imm = 0.
- Load-use hazard: ex_valid & ex_is_load & ex_rd != 0 & id_valid & a used rs matches ex_rd.
  - id_stall = 1.
  - ID/EX captures a bubble (ex_valid <= 0, other fields don't-care).
  - The instruction stays in ID.
- Update priority each edge: rst > flush > ex_hold > hazard bubble > normal capture.
  - flush: ex_valid <= 0; id_stall = 0.
  - ex_hold: all ID/EX fields keep value; id_stall = 1 if id_valid.
  - normal capture: ex_valid <= id_valid; fields from the current decode.
- id_valid = 0 in normal capture: ex_valid <= 0; id_stall = 0.
- Hazard with ex_hold both active: hold wins; id_stall = 1.
- Illegal opcode: captured normally with ex_illegal = 1, ex_rd = 0, operands not used.

Optional Feature:
WB_BYPASS_EN
- Defined: when wb_we & wb_rd != 0 & wb_rd equals a used rs, that operand takes wb_wd instead of rd1/rd2. No stall.
- Undefined: the same condition raises id_stall = 1 and inserts a bubble (same as a load-use hazard). Operands always come from rd1/rd2.
- In both builds, the load-use check takes precedence; both stall reasons OR into id_stall.

Test Plan:
- Reset, then ADDI x5,x1,-4 (0xFFC08293) with rd1 = 10 -> next cycle ex_valid = 1, ex_rd = 5, ex_rs1_val = 10, ex_imm = 0xFFFFFFFC, ex_rs2_val = 0.
- LW x3,0(x2) captured, then ADD x4,x3,x1 in ID -> id_stall = 1 for one cycle, bubble (ex_valid = 0), ADD captured on the following cycle.
- ADD x6,x7,x8 with wb_we = 1, wb_rd = 7, wb_wd = 0x55, rd1 = 0x11:
  - WB_BYPASS_EN defined -> ex_rs1_val = 0x55, no stall.
  - Undefined -> one stall cycle, then ex_rs1_val = rd1.
- ADD x1,x0,x0 with rd1 = rd2 = 0xDEAD and wb_we = 1, wb_rd = 0, wb_wd = 0x1234 -> both operands 0, no stall.
- ex_hold = 1 for 3 cycles with a valid instruction in ID -> ex_* frozen, id_stall = 1. Assert flush during the hold -> ex_valid = 0 on the next edge.
- BEQ with offset -8 (0xFE000CE3) -> ex_imm = 0xFFFFFFF8, ex_rd = 0. STORE SW x2,12(x1) -> ex_imm = 12, both operands captured.

Source files
------------

// File: rtl/id_operand_stage_if.sv
// id_operand_stage_if: fetch, register-file, writeback and ID/EX signals of the decode/operand stage
interface id_operand_stage_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            id_valid;
   logic [31:0]     id_instr;
   logic [XLEN-1:0] id_pc;
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic            wb_we;
   logic [AW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_wd;
   logic            ex_hold;
   logic            flush;
   logic            id_stall;
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc;
   logic [6:0]      ex_opcode;
   logic [2:0]      ex_funct3;
   logic            ex_funct7b5;
   logic [AW-1:0]   ex_rd;
   logic [XLEN-1:0] ex_rs1_val;
   logic [XLEN-1:0] ex_rs2_val;
   logic [XLEN-1:0] ex_imm;
   logic            ex_is_load;
   logic            ex_illegal;

   modport slave (
      input  id_valid, id_instr, id_pc, rd1, rd2, wb_we, wb_rd, wb_wd, ex_hold, flush,
      output rs1, rs2, id_stall, ex_valid, ex_pc, ex_opcode, ex_funct3, ex_funct7b5,
             ex_rd, ex_rs1_val, ex_rs2_val, ex_imm, ex_is_load, ex_illegal
   );

   modport master (
      output id_valid, id_instr, id_pc, rd1, rd2, wb_we, wb_rd, wb_wd, ex_hold, flush,
      input  rs1, rs2, id_stall, ex_valid, ex_pc, ex_opcode, ex_funct3, ex_funct7b5,
             ex_rd, ex_rs1_val, ex_rs2_val, ex_imm, ex_is_load, ex_illegal
   );
endinterface

// File: rtl/id_operand_stage.sv
// id_operand_stage: RV32I decode/operand fetch into ID/EX with load-use and writeback RAW stalls; define WB_BYPASS_EN to forward writeback data instead of stalling on it
module id_operand_stage #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input logic clk,
   input logic rst,
   id_operand_stage_if.slave bus
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

   logic [31:0]     instr;
   logic [6:0]      opcode;
   imm_fmt_e        fmt;
   logic            legal;
   logic            use_rs1;
   logic            use_rs2;
   logic            writes_rd;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm;
   logic [AW-1:0]   rd_dst;
   logic            load_use;
   logic            wb_hit1;
   logic            wb_hit2;
   logic            wb_hazard;
   logic            hazard;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;

   assign instr    = bus.id_instr;
   assign opcode   = instr[6:0];
   assign bus.rs1  = instr[19:15];
   assign bus.rs2  = instr[24:20];

   // Classify the opcode: immediate format, which sources are read, whether rd is written
   always_comb begin
      fmt       = IMM_NONE;
      legal     = 1'b1;
      use_rs1   = 1'b1;
      use_rs2   = 1'b0;
      writes_rd = 1'b1;
      case (opcode)
         OP_LUI, OP_AUIPC: begin
            fmt     = IMM_U;
            use_rs1 = 1'b0;
         end
         OP_JAL: begin
            fmt     = IMM_J;
            use_rs1 = 1'b0;
         end
         OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: fmt = IMM_I;
         OP_STORE: begin
            fmt       = IMM_S;
            use_rs2   = 1'b1;
            writes_rd = 1'b0;
         end
         OP_BRANCH: begin
            fmt       = IMM_B;
            use_rs2   = 1'b1;
            writes_rd = 1'b0;
         end
         OP_OP: use_rs2 = 1'b1;
         default: begin
            legal     = 1'b0;
            use_rs1   = 1'b0;
            writes_rd = 1'b0;
         end
      endcase
   end

   assign imm32 = (fmt == IMM_I) ? {{20{instr[31]}}, instr[31:20]} :
                  (fmt == IMM_S) ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                  (fmt == IMM_B) ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
                  (fmt == IMM_U) ? {instr[31:12], 12'b0} :
                  (fmt == IMM_J) ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
                  32'b0;
   assign imm    = XLEN'($signed(imm32));
   assign rd_dst = writes_rd ? instr[11:7] : '0;

   // A load in ID/EX has no data yet; any consumer of its rd must wait one cycle
   assign load_use = bus.ex_valid & bus.ex_is_load & (bus.ex_rd != '0) & bus.id_valid &
                     ((use_rs1 & (bus.rs1 == bus.ex_rd)) | (use_rs2 & (bus.rs2 == bus.ex_rd)));
   assign wb_hit1  = bus.wb_we & (bus.wb_rd != '0) & use_rs1 & (bus.rs1 == bus.wb_rd);
   assign wb_hit2  = bus.wb_we & (bus.wb_rd != '0) & use_rs2 & (bus.rs2 == bus.wb_rd);

`ifdef WB_BYPASS_EN
   assign wb_hazard = 1'b0;
   assign src1      = wb_hit1 ? bus.wb_wd : bus.rd1;
   assign src2      = wb_hit2 ? bus.wb_wd : bus.rd2;
`else
   logic unused_wb_wd;
   assign unused_wb_wd = ^bus.wb_wd;
   assign wb_hazard    = bus.id_valid & (wb_hit1 | wb_hit2);
   assign src1         = bus.rd1;
   assign src2         = bus.rd2;
`endif

   assign hazard = load_use | wb_hazard;
   assign op1    = (use_rs1 && bus.rs1 != '0) ? src1 : '0;
   assign op2    = (use_rs2 && bus.rs2 != '0) ? src2 : '0;

   assign bus.id_stall = !rst & !bus.flush & (bus.ex_hold ? bus.id_valid : hazard);

   // ID/EX register: reset, flush kills, hold freezes, hazard bubbles, otherwise capture
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ex_valid    <= 1'b0;
         bus.ex_pc       <= '0;
         bus.ex_opcode   <= '0;
         bus.ex_funct3   <= '0;
         bus.ex_funct7b5 <= 1'b0;
         bus.ex_rd       <= '0;
         bus.ex_rs1_val  <= '0;
         bus.ex_rs2_val  <= '0;
         bus.ex_imm      <= '0;
         bus.ex_is_load  <= 1'b0;
         bus.ex_illegal  <= 1'b0;
      end else if (bus.flush) begin
         bus.ex_valid <= 1'b0;
      end else if (!bus.ex_hold) begin
         bus.ex_valid <= bus.id_valid & !hazard;
         if (!hazard) begin
            bus.ex_pc       <= bus.id_pc;
            bus.ex_opcode   <= opcode;
            bus.ex_funct3   <= instr[14:12];
            bus.ex_funct7b5 <= instr[30];
            bus.ex_rd       <= rd_dst;
            bus.ex_rs1_val  <= op1;
            bus.ex_rs2_val  <= op2;
            bus.ex_imm      <= imm;
            bus.ex_is_load  <= (opcode == OP_LOAD);
            bus.ex_illegal  <= !legal;
         end
      end
   end
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed vector table, hand sequences and randomized run against a reference model
module tb_id_operand_stage;
   logic clk = 1'b0;
   logic rst;
   int   pass_cnt = 0;
   int   total = 0;

   id_operand_stage_if #(.XLEN(32), .AW(5)) bus ();
   id_operand_stage #(.XLEN(32), .AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam logic [31:0] ADDI  = 32'hFFC08293;
   localparam logic [31:0] LW    = 32'h00012183;
   localparam logic [31:0] ADD4  = 32'h00118233;
   localparam logic [31:0] ADD6  = 32'h00838333;
   localparam logic [31:0] ADD1  = 32'h000000B3;
   localparam logic [31:0] BEQ   = 32'hFE000CE3;
   localparam logic [31:0] SW    = 32'h0020A623;
   localparam logic [31:0] ILL   = 32'hFFFFFFFF;
   localparam logic [31:0] LW0   = 32'h00012003;
   localparam logic [31:0] ADD40 = 32'h00100233;

   typedef struct {
      logic r, v; logic [31:0] instr, pc, r1, r2; logic we; logic [4:0] wrd; logic [31:0] wd;
      logic hold, fl, e_stall, e_valid, chk, chk_imm; logic [4:0] e_rd; logic [31:0] e_v1, e_v2, e_imm;
   } vec_t;

   typedef struct {
      logic valid; logic [31:0] pc; logic [6:0] op; logic [2:0] f3; logic f7; logic [4:0] rd;
      logic [31:0] v1, v2, imm; logic ld, ill;
   } ex_t;

   typedef struct { byte f; logic u1, u2, wr; logic [31:0] imm; } dec_t;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input vec_t t);
      rst = t.r;
      bus.id_valid = t.v;
      bus.id_instr = t.instr;
      bus.id_pc = t.pc;
      bus.rd1 = t.r1;
      bus.rd2 = t.r2;
      bus.wb_we = t.we;
      bus.wb_rd = t.wrd;
      bus.wb_wd = t.wd;
      bus.ex_hold = t.hold;
      bus.flush = t.fl;
   endtask

   task automatic apply(input vec_t t, input string tag);
      drive(t);
      #1;
      check({tag, ".id_stall"}, bus.id_stall, t.e_stall);
      @(posedge clk);
      #1;
      check({tag, ".ex_valid"}, bus.ex_valid, t.e_valid);
      if (t.chk) begin
         check({tag, ".ex_rd"}, bus.ex_rd, t.e_rd);
         check({tag, ".ex_rs1_val"}, bus.ex_rs1_val, t.e_v1);
         check({tag, ".ex_rs2_val"}, bus.ex_rs2_val, t.e_v2);
      end
      if (t.chk_imm) check({tag, ".ex_imm"}, bus.ex_imm, t.e_imm);
   endtask

   // Format letter from the RV32I opcode map; immediates rebuilt by signed arithmetic
   function automatic dec_t decode(input logic [31:0] i);
      dec_t d;
      int s, hi;
      s = i;
      case (i[6:0])
         7'h37, 7'h17: d.f = "U";
         7'h6f: d.f = "J";
         7'h67, 7'h03, 7'h13, 7'h0f, 7'h73: d.f = "I";
         7'h23: d.f = "S";
         7'h63: d.f = "B";
         7'h33: d.f = "R";
         default: d.f = "X";
      endcase
      d.u1 = d.f inside {"I", "S", "B", "R"};
      d.u2 = d.f inside {"S", "B", "R"};
      d.wr = d.f inside {"I", "U", "J", "R"};
      d.imm = 32'h0;
      if (d.f == "I") begin
         hi = s >>> 20;
         d.imm = hi;
      end else if (d.f == "S") begin
         hi = s >>> 25;
         d.imm = (hi << 5) | 32'(i[11:7]);
      end else if (d.f == "B") begin
         hi = s >>> 31;
         d.imm = (hi << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      end else if (d.f == "U") begin
         d.imm = i & 32'hFFFFF000;
      end else if (d.f == "J") begin
         hi = s >>> 31;
         d.imm = (hi << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      end
      return d;
   endfunction

   function automatic logic reads(input dec_t d, input logic [31:0] i, input logic [4:0] r);
      return (d.u1 && i[19:15] == r) || (d.u2 && i[24:20] == r);
   endfunction

   vec_t tbl[$];
   vec_t seq[$];
   logic [6:0] ops[13];

   initial begin
      ex_t m;
      dec_t d;
      vec_t t;
      logic lu, haz, es;
      logic [4:0] s1, s2;
      logic [31:0] v1, v2;
      tbl.push_back('{1, 1, ADDI, 0, 10, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0});
      tbl.push_back('{0, 1, ADDI, 0, 10, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5, 10, 0, 32'hFFFFFFFC});
      tbl.push_back('{0, 1, LW, 0, 'h40, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 'h40, 0, 0});
      tbl.push_back('{0, 1, ADD4, 0, 7, 9, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 1, ADD4, 0, 7, 9, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4, 7, 9, 0});
      tbl.push_back('{0, 1, ADD6, 0, 'h11, 'h22, 1, 7, 'h55, 0, 0, !BYP, BYP, BYP, 0, 6, 'h55, 'h22, 0});
      tbl.push_back('{0, 1, ADD6, 0, 'h11, 'h22, 0, 0, 0, 0, 0, 0, 1, 1, 1, 6, 'h11, 'h22, 0});
      tbl.push_back('{0, 1, ADD1, 0, 'hDEAD, 'hDEAD, 1, 0, 'h1234, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0});
      tbl.push_back('{0, 1, BEQ, 0, 5, 6, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 32'hFFFFFFF8});
      tbl.push_back('{0, 1, ILL, 0, 5, 6, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 1, LW0, 0, 'h40, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 'h40, 0, 0});
      tbl.push_back('{0, 1, ADD40, 0, 3, 4, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4, 0, 4, 0});
      tbl.push_back('{0, 0, ADD40, 0, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 1, SW, 0, 'h100, 'h200, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 'h100, 'h200, 12});
      drive(tbl[0]);
      @(posedge clk);
      #1;
      foreach (tbl[k]) apply(tbl[k], $sformatf("vec%0d", k));
      for (int k = 0; k < 3; k++)
         apply('{0, 1, ADDI, 0, 'h999, 'h888, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 'h100, 'h200, 12}, $sformatf("hold%0d", k));
      apply('{0, 1, ADDI, 0, 'h999, 'h888, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0}, "hold_flush");
      seq.push_back('{0, 1, LW, 0, 'h40, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 'h40, 0, 0});
      seq.push_back('{0, 1, ADD4, 0, 7, 9, 0, 0, 0, 1, 0, 1, 1, 1, 1, 3, 'h40, 0, 0});
      seq.push_back('{0, 1, ADD4, 0, 7, 9, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
      seq.push_back('{0, 1, ADD4, 0, 7, 9, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4, 7, 9, 0});
      foreach (seq[k]) apply(seq[k], $sformatf("ld_hold%0d", k));

      ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73, 7'h7f, 7'h0b};
      m = '{default: 0};
      for (int n = 0; n < 3000; n++) begin
         t = '{default: 0};
         t.r = (n == 0) || ($urandom_range(0, 99) < 2);
         t.v = $urandom_range(0, 3) != 0;
         t.instr = $urandom;
         t.instr[6:0] = ops[$urandom_range(0, 12)];
         t.instr[11:7] = 5'($urandom_range(0, 3));
         t.instr[19:15] = 5'($urandom_range(0, 3));
         t.instr[24:20] = 5'($urandom_range(0, 3));
         t.pc = $urandom;
         t.r1 = $urandom;
         t.r2 = $urandom;
         t.we = 1'($urandom_range(0, 1));
         t.wrd = 5'($urandom_range(0, 3));
         t.wd = $urandom;
         t.hold = $urandom_range(0, 9) < 2;
         t.fl = $urandom_range(0, 9) < 1;
         d = decode(t.instr);
         s1 = t.instr[19:15];
         s2 = t.instr[24:20];
         lu = m.valid && m.ld && m.rd != 0 && t.v && reads(d, t.instr, m.rd);
         haz = lu || (!BYP && t.v && t.we && t.wrd != 0 && reads(d, t.instr, t.wrd));
         es = t.r ? 1'b0 : t.fl ? 1'b0 : t.hold ? t.v : haz;
         v1 = (!d.u1 || s1 == 0) ? 32'h0 : (BYP && t.we && t.wrd == s1) ? t.wd : t.r1;
         v2 = (!d.u2 || s2 == 0) ? 32'h0 : (BYP && t.we && t.wrd == s2) ? t.wd : t.r2;
         drive(t);
         #1;
         check("rnd.id_stall", bus.id_stall, es);
         check("rnd.rs", {bus.rs1, bus.rs2}, {s1, s2});
         if (t.r) m = '{default: 0};
         else if (t.fl) m.valid = 1'b0;
         else if (!t.hold) begin
            if (haz) m.valid = 1'b0;
            else m = '{t.v, t.pc, t.instr[6:0], t.instr[14:12], t.instr[30], d.wr ? t.instr[11:7] : 5'd0,
                       v1, v2, d.imm, t.instr[6:0] == 7'h03, d.f == "X"};
         end
         @(posedge clk);
         #1;
         check("rnd.ex_valid", bus.ex_valid, m.valid);
         if (m.valid || t.r)
            check("rnd.ex_fields",
                  {bus.ex_pc, bus.ex_opcode, bus.ex_funct3, bus.ex_funct7b5, bus.ex_rd, bus.ex_rs1_val,
                   bus.ex_rs2_val, bus.ex_imm, bus.ex_is_load, bus.ex_illegal},
                  {m.pc, m.op, m.f3, m.f7, m.rd, m.v1, m.v2, m.imm, m.ld, m.ill});
      end
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
